uart_rx_oversample: RTL and testbench

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

---
 rtl/uart_rx_oversample.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample -- 8-bit asynchronous serial receiver, 16x oversampled.
//
// The rx line is synchronised, and the start bit is confirmed at mid-bit.
// Each following bit is then sampled 16 oversample ticks later, which is
// again mid-bit. Framing is 8N1 by default.
// Optional build macro: UART_RX_PARITY_EN inserts one even-parity bit
// between the data bits and the stop bit. The port list is the same in
// both builds.
//
// Ports
//   CLK        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   EnClk      in   one-CLK-wide tick at 16x baud; the FSM advances only on it
//   rx         in   asynchronous serial line, idle high
//   ready_clr  in   single-cycle acknowledge of the held byte
//   rdout      out  [7:0] last received byte
//   ready      out  rdout holds an unacknowledged byte
//   frame_err  out  sticky: a stop bit was sampled low
//   overrun    out  sticky: a byte completed while ready was already high
//   parity_err out  sticky: parity mismatch (always 0 without the macro)
//   busy       out  FSM is not in IDLE
//   state_dbg  out  [2:0] current FSM state encoding
//
// Handshake: ready rises one CLK after the tick that samples a good stop bit.
// It stays high until a ready_clr pulse is seen. ready_clr also clears all
// sticky flags in the next cycle. A byte that completes in the same cycle as
// ready_clr takes priority: ready stays high and overrun is not raised.
module uart_rx_oversample #(
  parameter int SYNC_STAGES = 2  // legal 2..3
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       EnClk,
  input  logic       rx,
  input  logic       ready_clr,
  output logic [7:0] rdout,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state, state_n;
  logic [3:0] tick_cnt, tick_n;
  logic [2:0] bit_idx, idx_n;
  logic [7:0] shreg;
  logic       shift_en;
  logic       stop_ok;
  logic       stop_bad;

  // Synchroniser: resets to the idle level so that a reset is never
  // mistaken for a start bit.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge CLK) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par_en;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  // FSM state register, together with the tick counter and bit index.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= 4'd0;
      bit_idx  <= 3'd0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_idx  <= idx_n;
    end
  end

  // Next state logic. Nothing moves unless EnClk is high.
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    idx_n    = bit_idx;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
`endif
    if (EnClk) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            tick_n  = 4'd0;
          end
        end
        START: begin
          // The 8th tick is the middle of the start bit. A line that is
          // high again here was a glitch, so drop it silently.
          if (tick_cnt == 4'd7) begin
            tick_n  = 4'd0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
        DATA: begin
          tick_n = tick_cnt + 4'd1;  // wraps to 0 after the 16th tick
          if (tick_cnt == 4'd15) begin
            shift_en = 1'b1;
            idx_n    = bit_idx + 3'd1;  // wraps to 0 after bit 7
            if (bit_idx == 3'd7) state_n = AFTER_DATA;
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            par_en  = 1'b1;
            state_n = STOP;
          end
`else
          state_n = IDLE;
`endif
        end
        STOP: begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            stop_ok  = rx_s;
            stop_bad = !rx_s;
            state_n  = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          tick_n  = 4'd0;
          idx_n   = 3'd0;
        end
      endcase
    end
  end

  // Datapath and status flags. A set in the same cycle as ready_clr wins,
  // because the set assignments come after the clear.
  always_ff @(posedge CLK) begin
    if (rst) begin
      shreg     <= 8'h00;
      rdout     <= 8'h00;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (shift_en) shreg <= {rx_s, shreg[7:1]};  // LSB arrives first
      if (ready_clr) begin
        ready     <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (stop_ok) begin
        rdout <= shreg;
        ready <= 1'b1;
        if (ready && !ready_clr) overrun <= 1'b1;
      end
      if (stop_bad) frame_err <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  // Parity is judged when the frame ends, whatever the stop bit was.
  // Data bits XOR the parity bit must be 0 for even parity.
  always_ff @(posedge CLK) begin
    if (rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bit <= rx_s;
      if (ready_clr) parity_err <= 1'b0;
      if ((stop_ok || stop_bad) && (par_bit != ^shreg)) parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample -- self-checking bench for uart_rx_oversample.
// EnClk pulses every 4 CLK. Each serial bit is held for 16 ticks, and the
// line changes 2 ns after a tick edge. Expected bytes go into exp_q when a
// frame with a good stop bit is sent. They are popped and compared with
// rdout once the frame has completed.
module tb_uart_rx_oversample;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       EnClk = 1'b0;
  logic       rx = 1'b1;
  logic       ready_clr = 1'b0;
  logic [7:0] rdout;
  logic       ready, frame_err, overrun, parity_err, busy;
  logic [2:0] state_dbg;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       tick_on = 1'b1;
  int         div = 0;

  uart_rx_oversample #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .rst(rst), .EnClk(EnClk), .rx(rx), .ready_clr(ready_clr),
    .rdout(rdout), .ready(ready), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / tick generation ----------------
  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    #1;
    div   = (div + 1) % 4;
    EnClk = tick_on && (div == 0);
  end

  initial begin
    #2_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, rdout, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns 2 ns after the next CLK edge at which the DUT sees EnClk high.
  task automatic wait_tick();
    int budget = 0;
    do begin
      @(posedge CLK);
      budget++;
    end while (!EnClk && budget < 64);
    if (!EnClk) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: no EnClk within %0d cycles", budget);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "tick timeout");
    end
    #2;
  endtask

  task automatic pulse_clr();
    ready_clr = 1'b1;
    @(posedge CLK);
    #2;
    ready_clr = 1'b0;
  endtask

  // Stops the ticks for 200 CLK, which is a multiple of 4, so the tick
  // phase is unchanged when they resume. The FSM must hold its place.
  task automatic pause_ticks();
    tick_on = 1'b0;
    repeat (200) @(posedge CLK);
    #2;
    check("pause_busy", busy, 1'b1);
    check("pause_state", state_dbg, 3'd2);
    tick_on = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip,
                            input logic clr_at_stop, input int pause_bit,
                            input int stop_len, input logic align);
    if (align) wait_tick();
    rx = 1'b0;
    repeat (16) wait_tick();
    for (int i = 0; i < 8; i++) begin
      if (i == pause_bit) pause_ticks();
      rx = d[i];
      repeat (16) wait_tick();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (16) wait_tick();
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    rx = stop_v;
    if (clr_at_stop) begin
      repeat (8) wait_tick();
      // Raise ready_clr for exactly the cycle of the stop-sampling tick.
      do begin
        @(posedge CLK);
        #2;
      end while (!EnClk);
      pulse_clr();
      repeat (7) wait_tick();
    end else begin
      repeat (stop_len) wait_tick();
    end
    rx = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb;

    // reset state
    rst = 1'b1;
    repeat (4) @(posedge CLK);
    #2;
    rst = 1'b0;
    check("rst_rdout", rdout, 8'h00);
    check("rst_ready", ready, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (8) wait_tick();

    // 0x55 8N1, with the ticks stopped for a while before data bit 3
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 3, 16, 1'b1);
    pop_check("b55_rdout");
    check("b55_ready", ready, 1'b1);
    check("b55_frame_err", frame_err, 1'b0);
    check("b55_overrun", overrun, 1'b0);
    check("b55_parity_err", parity_err, 1'b0);
    check("b55_busy", busy, 1'b0);
    pulse_clr();
    check("b55_clr_ready", ready, 1'b0);

    // 0xA3 then 0x3C back-to-back. The short stop window puts the next
    // start bit on the first tick after the FSM returns to IDLE.
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0, -1, 9, 1'b1);
    pop_check("bA3_rdout");
    check("bA3_ready", ready, 1'b1);
    check("bA3_overrun", overrun, 1'b0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1, 16, 1'b0);
    pop_check("b3C_rdout");
    check("b3C_ready", ready, 1'b1);
    check("b3C_overrun", overrun, 1'b1);
    pulse_clr();
    check("b3C_clr_overrun", overrun, 1'b0);
    check("b3C_clr_ready", ready, 1'b0);

    // 0x81 with a low stop bit: frame_err set, rdout and ready unchanged
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1, 16, 1'b1);
    check("b81_frame_err", frame_err, 1'b1);
    check("b81_ready", ready, 1'b0);
    check("b81_rdout", rdout, 8'h3C);
    check("b81_overrun", overrun, 1'b0);
    repeat (6) wait_tick();
    check("b81_idle", busy, 1'b0);
    pulse_clr();
    check("b81_clr_frame_err", frame_err, 1'b0);

    // rx low for 3 ticks only: treated as a glitch and rejected
    wait_tick();
    rx = 1'b0;
    repeat (3) wait_tick();
    check("glitch_busy_mid", busy, 1'b1);
    rx = 1'b1;
    repeat (10) wait_tick();
    check("glitch_busy", busy, 1'b0);
    check("glitch_state", state_dbg, 3'd0);
    check("glitch_ready", ready, 1'b0);
    check("glitch_frame_err", frame_err, 1'b0);
    check("glitch_overrun", overrun, 1'b0);

    // random frames, each acknowledged
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      send_frame(rb, 1'b1, 1'b0, 1'b0, -1, 16, 1'b1);
      pop_check("rand_rdout");
      check("rand_ready", ready, 1'b1);
      check("rand_overrun", overrun, 1'b0);
      if (k < 2) pulse_clr();
    end

    // ready is still high; a ready_clr in the completion cycle must not
    // raise overrun, and ready must stay high
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b0, 1'b1, -1, 16, 1'b1);
    pop_check("b99_rdout");
    check("b99_ready", ready, 1'b1);
    check("b99_overrun", overrun, 1'b0);
    pulse_clr();

`ifdef UART_RX_PARITY_EN
    // 0x07 carries parity bit 0, which is odd parity, so it is an error
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1, 16, 1'b1);
    pop_check("b07_rdout");
    check("b07_parity_err", parity_err, 1'b1);
    check("b07_ready", ready, 1'b1);
    check("b07_frame_err", frame_err, 1'b0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, -1, 16, 1'b1);
    pop_check("b5A_rdout");
    check("b5A_ready", ready, 1'b1);
    check("b5A_overrun", overrun, 1'b0);
    check("b5A_parity_err", parity_err, 1'b0);
    pulse_clr();
`endif

    // reset in the middle of data bit 4 of 0xF0, then a clean 0x0F
    wait_tick();
    rx = 1'b0;
    repeat (16) wait_tick();
    for (int i = 0; i < 4; i++) repeat (16) wait_tick();  // bits 0..3 = 0
    rx = 1'b1;
    repeat (8) wait_tick();
    rst = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    rst = 1'b0;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rdout", rdout, 8'h00);
    check("rst_mid_ready", ready, 1'b0);
    check("rst_mid_frame_err", frame_err, 1'b0);
    repeat (20) wait_tick();
    check("rst_mid_idle", busy, 1'b0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1, 16, 1'b1);
    pop_check("b0F_rdout");
    check("b0F_ready", ready, 1'b1);
    check("b0F_frame_err", frame_err, 1'b0);
    check("b0F_overrun", overrun, 1'b0);
    check("b0F_parity_err", parity_err, 1'b0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
